// File: rtl/alavanca_frame_pkg.sv
// Shared definitions for the lever frame parser: state codes, sync marker and frame length.
package alavanca_frame_pkg;

    typedef enum logic [2:0] {
        StHunt = 3'd0,
        StA1h  = 3'd1,
        StA1l  = 3'd2,
        StA2h  = 3'd3,
        StA2l  = 3'd4,
        StChk  = 3'd5
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned FRAME_LEN         = 6;

endpackage

// File: rtl/hexa7seg.sv
// Hex digit to 7-segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
module hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] display
);

    always_comb begin
        display = 7'b1111111;
        unique case (hexa)
            4'h0: display = 7'b1000000;
            4'h1: display = 7'b1111001;
            4'h2: display = 7'b0100100;
            4'h3: display = 7'b0110000;
            4'h4: display = 7'b0011001;
            4'h5: display = 7'b0010010;
            4'h6: display = 7'b0000010;
            4'h7: display = 7'b1111000;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0010000;
            4'hA: display = 7'b0001000;
            4'hB: display = 7'b0000011;
            4'hC: display = 7'b1000110;
            4'hD: display = 7'b0100001;
            4'hE: display = 7'b0000110;
            4'hF: display = 7'b0001110;
            default: display = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/alavanca_frame_parser.sv
// Assembles SYNC/A1H/A1L/A2H/A2L/CHK byte frames into two signed lever values,
// with XOR checksum, inter-byte timeout, link liveness and a saturating error count.
module alavanca_frame_parser
    import alavanca_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 500_000,
    parameter int unsigned STALE_CYCLES   = 5_000_000,
    parameter int unsigned ERR_W          = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic signed [15:0] al1Bits,
    output logic signed [15:0] al2Bits,
    output logic               frame_ok,
    output logic               frame_err,
    output logic               link_ok,
    output logic [ERR_W-1:0]   err_count,
    output logic [6:0]         db_estado
);

    localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned   SW         = $clog2(STALE_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STALE_LAST = SW'(STALE_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] stale_cnt;
    logic [SW-1:0] stale_inc;
    logic [15:0]   shadow1;
    logic [15:0]   shadow2;
    logic [7:0]    chk_acc;
    logic          timeout_hit;

    assign stale_inc = stale_cnt + 1'b1;
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_hit = (state != StHunt) && !rx_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StHunt;
            tmo_cnt   <= '0;
            stale_cnt <= '0;
            shadow1   <= '0;
            shadow2   <= '0;
            chk_acc   <= '0;
            al1Bits   <= '0;
            al2Bits   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            link_ok   <= 1'b0;
            err_count <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (stale_cnt != STALE_LAST) begin
                stale_cnt <= stale_inc;
                if (stale_inc == STALE_LAST) begin
                    link_ok <= 1'b0;
                end
            end

            if (state != StHunt) begin
                tmo_cnt <= rx_valid ? '0 : tmo_cnt + 1'b1;
            end

            if (rx_valid) begin
                unique case (state)
                    StHunt: begin
                        if (rx_data == SYNC_BYTE) begin
                            state   <= StA1h;
                            chk_acc <= '0;
                            tmo_cnt <= '0;
                        end
                    end
                    StA1h: begin
                        shadow1[15:8] <= rx_data;
                        chk_acc       <= chk_acc ^ rx_data;
                        state         <= StA1l;
                    end
                    StA1l: begin
                        shadow1[7:0] <= rx_data;
                        chk_acc      <= chk_acc ^ rx_data;
                        state        <= StA2h;
                    end
                    StA2h: begin
                        shadow2[15:8] <= rx_data;
                        chk_acc       <= chk_acc ^ rx_data;
                        state         <= StA2l;
                    end
                    StA2l: begin
                        shadow2[7:0] <= rx_data;
                        chk_acc      <= chk_acc ^ rx_data;
                        state        <= StChk;
                    end
                    StChk: begin
                        if (rx_data == chk_acc) begin
                            al1Bits   <= shadow1;
                            al2Bits   <= shadow2;
                            frame_ok  <= 1'b1;
                            link_ok   <= 1'b1;
                            stale_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                            if (err_count != {ERR_W{1'b1}}) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                        state   <= StHunt;
                        tmo_cnt <= '0;
                    end
                    default: state <= StHunt;
                endcase
            end else if (timeout_hit) begin
                state     <= StHunt;
                tmo_cnt   <= '0;
                shadow1   <= '0;
                shadow2   <= '0;
                chk_acc   <= '0;
                frame_err <= 1'b1;
                if (err_count != {ERR_W{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

    hexa7seg u_hexa7seg (
        .hexa    ({1'b0, state}),
        .display (db_estado)
    );

endmodule
